stack_ctrl_v2: RTL and testbench

Parametrised multicycle controller for the stack-machine datapath, the next generation of the 3-bit-opcode controller. It widens the opcode to 4 bits and adds DUP, DROP and HALT. It tracks stack occupancy internally and faults on underflow, overflow or an illegal opcode. It also supports variable-latency memory through a `mem_ready` handshake and emits a per-instruction retire pulse.

---
 rtl/stack_ctrl_pkg.sv | 53 +++++
 rtl/stack_ctrl_v2_if.sv | 43 ++++
 rtl/stack_depth_tracker.sv | 33 +++
 rtl/stack_ctrl_v2.sv | 202 ++++++++++++++++++++
 tb/tb_stack_ctrl_v2.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared types and encodings for the stack-machine controller:
// FSM states, opcodes, push-source selects and fault codes.
package stack_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_POP_X,
        S_POP_Y,
        S_EXEC,
        S_MEM,
        S_JUMP,
        S_PUSH_A,
        S_PUSH_B,
        S_HALT,
        S_FAULT
    } ctrl_state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_PUSH = 4'b0100;
    localparam logic [3:0] OP_POP  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_JZ   = 4'b0111;
    localparam logic [3:0] OP_DUP  = 4'b1000;
    localparam logic [3:0] OP_DROP = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1010;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_X   = 2'b10;

    localparam logic [1:0] FLT_NONE      = 2'b00;
    localparam logic [1:0] FLT_UNDERFLOW = 2'b01;
    localparam logic [1:0] FLT_OVERFLOW  = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL   = 2'b11;

    // Stack entries an opcode must find before it may start.
    function automatic logic [1:0] min_entries(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND:                    return 2'd2;
            OP_NOT, OP_POP, OP_JZ, OP_DUP, OP_DROP:    return 2'd1;
            default:                                   return 2'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_HALT;
    endfunction

endpackage

// File: rtl/stack_ctrl_v2_if.sv
// Controller <-> datapath bundle: opcode/status in, strobes and status out.
// The master side is the controller.
interface stack_ctrl_v2_if #(
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [3:0]      op_code;
    logic            nor_top;
    logic            mem_ready;
    logic            ir_write;
    logic            pc_update;
    logic            pc_write;
    logic            adr_src;
    logic            mem_read;
    logic            mem_write;
    logic            push;
    logic            pop;
    logic            x_write;
    logic            y_write;
    logic [1:0]      stack_src;
    logic [1:0]      alu_control;
    logic [SP_W-1:0] sp_count;
    logic            instr_done;
    logic            halted;
    logic            fault;
    logic [1:0]      fault_code;

    modport master (
        input  op_code, nor_top, mem_ready,
        output ir_write, pc_update, pc_write, adr_src, mem_read, mem_write,
               push, pop, x_write, y_write, stack_src, alu_control,
               sp_count, instr_done, halted, fault, fault_code
    );

    modport slave (
        output op_code, nor_top, mem_ready,
        input  ir_write, pc_update, pc_write, adr_src, mem_read, mem_write,
               push, pop, x_write, y_write, stack_src, alu_control,
               sp_count, instr_done, halted, fault, fault_code
    );

endinterface

// File: rtl/stack_depth_tracker.sv
// Stack occupancy counter driven by the push/pop strobes; saturates at
// both ends so it stays meaningful when the controller's checks are off.
module stack_depth_tracker #(
    parameter int unsigned STACK_DEPTH = 8,
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    output logic [SP_W-1:0] sp_count,
    output logic            can_pop1,
    output logic            can_pop2,
    output logic            can_push
);

    localparam logic [SP_W-1:0] FULL = SP_W'(STACK_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_count <= '0;
        end else if (push && !pop && sp_count != FULL) begin
            sp_count <= sp_count + 1'b1;
        end else if (pop && !push && sp_count != '0) begin
            sp_count <= sp_count - 1'b1;
        end
    end

    assign can_pop1 = (sp_count >= SP_W'(1));
    assign can_pop2 = (sp_count >= SP_W'(2));
    assign can_push = (sp_count != FULL);

endmodule

// File: rtl/stack_ctrl_v2.sv
// Multicycle stack-machine controller with occupancy checks, variable
// memory latency (mem_ready), retire pulse and sticky halt/fault status.
module stack_ctrl_v2
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8,
    parameter bit          CHECK_STACK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    stack_ctrl_v2_if.master bus
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    ctrl_state_t     state, state_next;
    logic [1:0]      fault_code_next;
    logic [1:0]      need;
    logic [3:0]      op;
    logic            mem_ready;
    logic            ir_write, pc_update, pc_write, adr_src;
    logic            mem_read, mem_write, push, pop, x_write, y_write;
    logic            instr_done;
    logic [1:0]      stack_src, alu_control;
    logic            can_pop1, can_pop2, can_push;
    logic [SP_W-1:0] sp_count;
    logic            halted, fault;
    logic [1:0]      fault_code;

    assign op        = bus.op_code;
    assign mem_ready = bus.mem_ready;

    stack_depth_tracker #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_depth (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .sp_count (sp_count),
        .can_pop1 (can_pop1),
        .can_pop2 (can_pop2),
        .can_push (can_push)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        fault_code_next = FLT_NONE;
        need            = min_entries(op);
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                // Check priority: illegal, then underflow, then overflow.
                if (!is_legal(op)) begin
                    state_next      = S_FAULT;
                    fault_code_next = FLT_ILLEGAL;
                end else if (CHECK_STACK && ((need == 2'd2 && !can_pop2) ||
                                             (need == 2'd1 && !can_pop1))) begin
                    state_next      = S_FAULT;
                    fault_code_next = FLT_UNDERFLOW;
                end else if (CHECK_STACK && (op == OP_PUSH || op == OP_DUP) && !can_push) begin
                    state_next      = S_FAULT;
                    fault_code_next = FLT_OVERFLOW;
                end else begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_NOT,
                        OP_DUP, OP_DROP:                state_next = S_POP_X;
                        OP_PUSH, OP_POP:                state_next = S_MEM;
                        OP_JMP, OP_JZ:                  state_next = S_JUMP;
                        default:                        state_next = S_HALT;
                    endcase
                end
            end
            S_POP_X: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND: state_next = S_POP_Y;
                    OP_NOT:                 state_next = S_EXEC;
                    OP_DUP:                 state_next = S_PUSH_A;
                    default:                state_next = S_FETCH;
                endcase
            end
            S_POP_Y:  state_next = S_EXEC;
            S_EXEC:   state_next = S_FETCH;
            S_MEM:    if (mem_ready) state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_PUSH_A: state_next = S_PUSH_B;
            S_PUSH_B: state_next = S_FETCH;
            default:  state_next = state;
        endcase
    end

    // Strobes are forced low while rst is held, even though state reads FETCH.
    always_comb begin
        ir_write    = 1'b0;
        pc_update   = 1'b0;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        x_write     = 1'b0;
        y_write     = 1'b0;
        stack_src   = SRC_ALU;
        alu_control = 2'b00;
        instr_done  = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_ready;
                    pc_update = mem_ready;
                end
                S_DECODE: adr_src = 1'b1;
                S_POP_X: begin
                    x_write    = 1'b1;
                    pop        = 1'b1;
                    instr_done = (op == OP_DROP);
                end
                S_POP_Y: begin
                    y_write = 1'b1;
                    pop     = 1'b1;
                end
                S_EXEC: begin
                    push        = 1'b1;
                    stack_src   = SRC_ALU;
                    alu_control = op[1:0];
                    instr_done  = 1'b1;
                end
                S_MEM: begin
                    adr_src    = 1'b1;
                    instr_done = mem_ready;
                    if (op == OP_PUSH) begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            push      = 1'b1;
                            stack_src = SRC_MEM;
                        end
                    end else if (mem_ready) begin
                        mem_write = 1'b1;
                        pop       = 1'b1;
                    end
                end
                S_JUMP: begin
                    pc_write   = (op == OP_JZ) ? bus.nor_top : 1'b1;
                    instr_done = 1'b1;
                end
                S_PUSH_A: begin
                    push      = 1'b1;
                    stack_src = SRC_X;
                end
                S_PUSH_B: begin
                    push       = 1'b1;
                    stack_src  = SRC_X;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end else if (state == S_DECODE) begin
            if (state_next == S_FAULT) begin
                fault      <= 1'b1;
                fault_code <= fault_code_next;
            end
            if (state_next == S_HALT) halted <= 1'b1;
        end
    end

    assign bus.ir_write    = ir_write;
    assign bus.pc_update   = pc_update;
    assign bus.pc_write    = pc_write;
    assign bus.adr_src     = adr_src;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.push        = push;
    assign bus.pop         = pop;
    assign bus.x_write     = x_write;
    assign bus.y_write     = y_write;
    assign bus.stack_src   = stack_src;
    assign bus.alu_control = alu_control;
    assign bus.sp_count    = sp_count;
    assign bus.instr_done  = instr_done;
    assign bus.halted      = halted;
    assign bus.fault       = fault;
    assign bus.fault_code  = fault_code;

endmodule

// File: tb/tb_stack_ctrl_v2.sv
// Directed bench for stack_ctrl_v2 (STACK_DEPTH=8, checks enabled):
// latencies, handshake stalls, jumps, DUP, faults, halt and mid-instruction reset.
module tb_stack_ctrl_v2;
    import stack_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_ctrl_v2_if #(.STACK_DEPTH(8)) bus ();

    stack_ctrl_v2 #(
        .STACK_DEPTH(8),
        .CHECK_STACK(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec, n_err;
    int n_irw, n_pcu, n_pcw, n_pop, n_push, n_mw, n_srcx, n_done_total, irw_at;
    logic [1:0] last_alu;
    int cyc;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] strobes();
        return {bus.ir_write, bus.pc_update, bus.pc_write, bus.adr_src,
                bus.mem_read, bus.mem_write, bus.push, bus.pop, bus.x_write,
                bus.y_write, bus.stack_src, bus.alu_control, bus.instr_done};
    endfunction

    // Runs one instruction from FETCH; fw = fetch stall cycles, mw = MEM stall cycles.
    // cyc = cycles up to and including the retire pulse, or the cycle index at
    // which halted/fault became visible; -1 if nothing happened within the budget.
    task automatic run_op(input logic [3:0] op, input int fw, input int mw,
                          input logic nz, output int cyc_o);
        n_irw = 0; n_pcu = 0; n_pcw = 0; n_pop = 0; n_push = 0; n_mw = 0;
        n_srcx = 0; irw_at = -1; last_alu = 2'b10; cyc_o = -1;
        bus.op_code = op;
        bus.nor_top = nz;
        for (int k = 0; k < 40; k++) begin
            bus.mem_ready = !((k < fw) || (k >= fw + 2 && k < fw + 2 + mw));
            #1;
            if (bus.fault || bus.halted) begin
                cyc_o = k;
                @(negedge clk);
                break;
            end
            if (bus.ir_write) begin
                n_irw++;
                if (irw_at < 0) irw_at = k;
            end
            if (bus.pc_update) n_pcu++;
            if (bus.pc_write)  n_pcw++;
            if (bus.pop)       n_pop++;
            if (bus.mem_write) n_mw++;
            if (bus.push) begin
                n_push++;
                if (bus.stack_src == SRC_X)   n_srcx++;
                if (bus.stack_src == SRC_ALU) last_alu = bus.alu_control;
            end
            if (bus.instr_done) begin
                n_done_total++;
                cyc_o = k + 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            check_eq(tag, int'(strobes()), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0; n_done_total = 0;
        rst = 1'b1;
        bus.op_code = 4'b0000; bus.nor_top = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_sp", int'(bus.sp_count), 0);
        check_eq("rst_halted", int'(bus.halted), 0);
        check_eq("rst_fault", int'(bus.fault), 0);
        check_eq("rst_fcode", int'(bus.fault_code), 0);
        check_eq("rst_strobes", int'(strobes()), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_PUSH, 0, 0, 1'b0, cyc);
        check_eq("push1_cyc", cyc, 3);
        check_eq("push1_sp", int'(bus.sp_count), 1);
        run_op(OP_PUSH, 0, 0, 1'b0, cyc);
        check_eq("push2_sp", int'(bus.sp_count), 2);
        run_op(OP_ADD, 0, 0, 1'b0, cyc);
        check_eq("add_cyc", cyc, 5);
        check_eq("add_sp", int'(bus.sp_count), 1);
        check_eq("add_alu", int'(last_alu), 0);
        check_eq("add_pops", n_pop, 2);
        check_eq("done_total", n_done_total, 3);

        run_op(OP_PUSH, 3, 0, 1'b0, cyc);
        check_eq("fwait_cyc", cyc, 6);
        check_eq("fwait_irw_at", irw_at, 3);
        check_eq("fwait_irw_n", n_irw, 1);
        check_eq("fwait_pcu_n", n_pcu, 1);
        check_eq("fwait_sp", int'(bus.sp_count), 2);

        run_op(OP_POP, 0, 2, 1'b0, cyc);
        check_eq("mwait_cyc", cyc, 5);
        check_eq("mwait_mw", n_mw, 1);
        check_eq("mwait_pop", n_pop, 1);
        check_eq("mwait_sp", int'(bus.sp_count), 1);

        run_op(OP_JZ, 0, 0, 1'b0, cyc);
        check_eq("jz0_cyc", cyc, 3);
        check_eq("jz0_pcw", n_pcw, 0);
        check_eq("jz0_sp", int'(bus.sp_count), 1);
        run_op(OP_JZ, 0, 0, 1'b1, cyc);
        check_eq("jz1_pcw", n_pcw, 1);
        check_eq("jz1_sp", int'(bus.sp_count), 1);
        run_op(OP_JMP, 0, 0, 1'b0, cyc);
        check_eq("jmp_cyc", cyc, 3);
        check_eq("jmp_pcw", n_pcw, 1);

        run_op(OP_NOT, 0, 0, 1'b0, cyc);
        check_eq("not_cyc", cyc, 4);
        check_eq("not_alu", int'(last_alu), 3);
        check_eq("not_sp", int'(bus.sp_count), 1);
        run_op(OP_DROP, 0, 0, 1'b0, cyc);
        check_eq("drop_cyc", cyc, 3);
        check_eq("drop_sp", int'(bus.sp_count), 0);

        for (int i = 0; i < 7; i++) run_op(OP_PUSH, 0, 0, 1'b0, cyc);
        check_eq("push7_sp", int'(bus.sp_count), 7);
        run_op(OP_DUP, 0, 0, 1'b0, cyc);
        check_eq("dup_cyc", cyc, 5);
        check_eq("dup_srcx", n_srcx, 2);
        check_eq("dup_push", n_push, 2);
        check_eq("dup_sp", int'(bus.sp_count), 8);

        run_op(OP_PUSH, 0, 0, 1'b0, cyc);
        check_eq("ovf_cyc", cyc, 2);
        check_eq("ovf_fault", int'(bus.fault), 1);
        check_eq("ovf_fcode", int'(bus.fault_code), 2);
        check_eq("ovf_sp", int'(bus.sp_count), 8);
        idle_zero("ovf_idle");
        check_eq("ovf_sticky", int'(bus.fault), 1);

        do_reset();
        check_eq("rst2_fault", int'(bus.fault), 0);
        check_eq("rst2_sp", int'(bus.sp_count), 0);
        run_op(OP_ADD, 0, 0, 1'b0, cyc);
        check_eq("unf_cyc", cyc, 2);
        check_eq("unf_fcode", int'(bus.fault_code), 1);
        check_eq("unf_pops", n_pop, 0);

        do_reset();
        run_op(4'b1100, 0, 0, 1'b0, cyc);
        check_eq("ill_cyc", cyc, 2);
        check_eq("ill_fcode", int'(bus.fault_code), 3);

        do_reset();
        run_op(OP_PUSH, 0, 0, 1'b0, cyc);
        run_op(OP_HALT, 0, 0, 1'b0, cyc);
        check_eq("halt_cyc", cyc, 2);
        check_eq("halt_flag", int'(bus.halted), 1);
        check_eq("halt_nofault", int'(bus.fault), 0);
        idle_zero("halt_idle");
        check_eq("halt_sticky", int'(bus.halted), 1);

        do_reset();
        run_op(OP_PUSH, 0, 0, 1'b0, cyc);
        run_op(OP_PUSH, 0, 0, 1'b0, cyc);
        bus.op_code = OP_ADD;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            @(negedge clk);
        end
        #1;
        check_eq("popy_ywrite", int'(bus.y_write), 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_sp", int'(bus.sp_count), 0);
        check_eq("midrst_strobes", int'(strobes()), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_fetch", int'({bus.mem_read, bus.adr_src}), 2);
        check_eq("midrst_sp_after", int'(bus.sp_count), 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
